// File: rtl/read_upsize.sv
// read_upsize: AXI4 read-channel width converter, 32-bit slave port to 128-bit master port.
// One burst in flight; each wide R beat is held in a one-entry buffer and replayed as narrow beats.
module read_upsize #(
    parameter int AXI_ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH_IN  = 32,
    parameter int AXI_DATA_WIDTH_OUT = 128,
    parameter int AXI_ID_WIDTH       = 5,
    parameter int AXI_USER_WIDTH     = 6
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          s_ar_valid_i,
    output logic                          s_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_ar_addr_i,
    input  logic [7:0]                    s_ar_len_i,
    input  logic [2:0]                    s_ar_size_i,
    input  logic [1:0]                    s_ar_burst_i,
    input  logic [2:0]                    s_ar_prot_i,
    input  logic [3:0]                    s_ar_region_i,
    input  logic                          s_ar_lock_i,
    input  logic [3:0]                    s_ar_cache_i,
    input  logic [3:0]                    s_ar_qos_i,
    input  logic [AXI_ID_WIDTH-1:0]       s_ar_id_i,
    input  logic [AXI_USER_WIDTH-1:0]     s_ar_user_i,

    output logic                          s_r_valid_o,
    input  logic                          s_r_ready_i,
    output logic [AXI_DATA_WIDTH_IN-1:0]  s_r_data_o,
    output logic [1:0]                    s_r_resp_o,
    output logic                          s_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]       s_r_id_o,
    output logic [AXI_USER_WIDTH-1:0]     s_r_user_o,

    output logic                          m_ar_valid_o,
    input  logic                          m_ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]     m_ar_addr_o,
    output logic [7:0]                    m_ar_len_o,
    output logic [2:0]                    m_ar_size_o,
    output logic [1:0]                    m_ar_burst_o,
    output logic [2:0]                    m_ar_prot_o,
    output logic [3:0]                    m_ar_region_o,
    output logic                          m_ar_lock_o,
    output logic [3:0]                    m_ar_cache_o,
    output logic [3:0]                    m_ar_qos_o,
    output logic [AXI_ID_WIDTH-1:0]       m_ar_id_o,
    output logic [AXI_USER_WIDTH-1:0]     m_ar_user_o,

    input  logic                          m_r_valid_i,
    output logic                          m_r_ready_o,
    input  logic [AXI_DATA_WIDTH_OUT-1:0] m_r_data_i,
    input  logic [1:0]                    m_r_resp_i,
    input  logic                          m_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]       m_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0]     m_r_user_i
);

    localparam int IN_BYTES  = AXI_DATA_WIDTH_IN / 8;
    localparam int OUT_BYTES = AXI_DATA_WIDTH_OUT / 8;
    localparam int MAX_SIZE  = $clog2(IN_BYTES);
    localparam int WIDE_SIZE = $clog2(OUT_BYTES);
    localparam int RATIO     = AXI_DATA_WIDTH_OUT / AXI_DATA_WIDTH_IN;
    localparam int LANE_BITS = $clog2(RATIO);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        AR_SEND,
        DATA
    } state_t;

    state_t state, state_next;

    logic [AXI_ADDR_WIDTH-1:0]     cur_addr;
    logic [7:0]                    ar_len;
    logic [2:0]                    ar_size;
    logic [1:0]                    ar_burst;
    logic [AXI_ID_WIDTH-1:0]       ar_id;
    logic [7:0]                    beat_cnt;

    logic                          buf_valid;
    logic [AXI_DATA_WIDTH_OUT-1:0] buf_data;
    logic [1:0]                    buf_resp;
    logic [AXI_USER_WIDTH-1:0]     buf_user;

    logic ar_fire, wide_fire, narrow_fire;
    logic last_beat, buf_release;

    function automatic logic [AXI_ADDR_WIDTH-1:0] size_mask(input logic [2:0] size);
        return (AXI_ADDR_WIDTH'(1) << size) - AXI_ADDR_WIDTH'(1);
    endfunction

    // Incoming AR: clamp unsupported sizes and derive the wide INCR length.
    logic [2:0]                in_size;
    logic                      in_incr;
    logic [AXI_ADDR_WIDTH-1:0] in_aligned, in_last_byte, in_block_diff;

    always_comb begin
        in_size       = (s_ar_size_i > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : s_ar_size_i;
        in_incr       = (s_ar_burst_i != BURST_FIXED) && (s_ar_burst_i != BURST_WRAP);
        in_aligned    = s_ar_addr_i & ~size_mask(in_size);
        in_last_byte  = in_aligned + (AXI_ADDR_WIDTH'(s_ar_len_i) << in_size);
        in_block_diff = (in_last_byte >> WIDE_SIZE) - (s_ar_addr_i >> WIDE_SIZE);
    end

    // Address of the next narrow beat, following the AXI burst rules.
    logic [AXI_ADDR_WIDTH-1:0] step_addr, wrap_mask, next_addr;
    logic                      crosses;

    always_comb begin
        step_addr = (cur_addr & ~size_mask(ar_size)) + (AXI_ADDR_WIDTH'(1) << ar_size);
        wrap_mask = ((AXI_ADDR_WIDTH'(ar_len) + AXI_ADDR_WIDTH'(1)) << ar_size) - AXI_ADDR_WIDTH'(1);
        case (ar_burst)
            BURST_FIXED: next_addr = cur_addr;
            BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (step_addr & wrap_mask);
            default:     next_addr = step_addr;
        endcase
        crosses = next_addr[AXI_ADDR_WIDTH-1:WIDE_SIZE] != cur_addr[AXI_ADDR_WIDTH-1:WIDE_SIZE];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output and next-state is defaulted first so no path leaves a latch.
    always_comb begin
        state_next   = state;
        s_ar_ready_o = 1'b0;
        m_ar_valid_o = 1'b0;
        m_r_ready_o  = 1'b0;
        s_r_valid_o  = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    s_ar_ready_o = 1'b1;
                    if (s_ar_valid_i) state_next = AR_SEND;
                end
                AR_SEND: begin
                    m_ar_valid_o = 1'b1;
                    if (m_ar_ready_i) state_next = DATA;
                end
                DATA: begin
                    m_r_ready_o = ~buf_valid;
                    s_r_valid_o = buf_valid;
                    if (buf_valid && s_r_ready_i && last_beat) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign ar_fire     = s_ar_ready_o & s_ar_valid_i;
    assign wide_fire   = m_r_ready_o & m_r_valid_i;
    assign narrow_fire = s_r_valid_o & s_r_ready_i;
    assign last_beat   = beat_cnt == ar_len;
    // FIXED and WRAP map one narrow beat to one wide beat; INCR drains a wide beat lane by lane.
    assign buf_release = crosses || (ar_burst == BURST_FIXED) || (ar_burst == BURST_WRAP) || last_beat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_addr      <= '0;
            ar_len        <= '0;
            ar_size       <= '0;
            ar_burst      <= '0;
            ar_id         <= '0;
            beat_cnt      <= '0;
            m_ar_addr_o   <= '0;
            m_ar_len_o    <= '0;
            m_ar_size_o   <= '0;
            m_ar_burst_o  <= '0;
            m_ar_prot_o   <= '0;
            m_ar_region_o <= '0;
            m_ar_lock_o   <= 1'b0;
            m_ar_cache_o  <= '0;
            m_ar_qos_o    <= '0;
            m_ar_user_o   <= '0;
            buf_valid     <= 1'b0;
            // NOTE: the buffer contents are reset as well so narrow data reads as zero after reset.
            buf_data      <= '0;
            buf_resp      <= '0;
            buf_user      <= '0;
        end else begin
            if (ar_fire) begin
                cur_addr      <= s_ar_addr_i;
                ar_len        <= s_ar_len_i;
                ar_size       <= in_size;
                ar_burst      <= s_ar_burst_i;
                ar_id         <= s_ar_id_i;
                beat_cnt      <= '0;
                m_ar_addr_o   <= in_incr ? (s_ar_addr_i & ~AXI_ADDR_WIDTH'(OUT_BYTES - 1)) : s_ar_addr_i;
                m_ar_len_o    <= in_incr ? in_block_diff[7:0] : s_ar_len_i;
                m_ar_size_o   <= in_incr ? 3'(WIDE_SIZE) : in_size;
                m_ar_burst_o  <= s_ar_burst_i;
                m_ar_prot_o   <= s_ar_prot_i;
                m_ar_region_o <= s_ar_region_i;
                m_ar_lock_o   <= s_ar_lock_i;
                m_ar_cache_o  <= s_ar_cache_i;
                m_ar_qos_o    <= s_ar_qos_i;
                m_ar_user_o   <= s_ar_user_i;
            end
            if (wide_fire) begin
                buf_valid <= 1'b1;
                buf_data  <= m_r_data_i;
                buf_resp  <= m_r_resp_i;
                buf_user  <= m_r_user_i;
            end
            if (narrow_fire) begin
                beat_cnt <= beat_cnt + 8'd1;
                cur_addr <= next_addr;
                if (buf_release) buf_valid <= 1'b0;
            end
        end
    end

    // Narrow lane selected by the current beat address.
    logic [AXI_DATA_WIDTH_IN-1:0] lanes [RATIO];
    logic [LANE_BITS-1:0]         lane;

    always_comb begin
        for (int i = 0; i < RATIO; i++) lanes[i] = buf_data[i*AXI_DATA_WIDTH_IN +: AXI_DATA_WIDTH_IN];
        lane = cur_addr[WIDE_SIZE-1:MAX_SIZE];
    end

    assign s_r_data_o = lanes[lane];
    assign s_r_resp_o = buf_resp;
    assign s_r_user_o = buf_user;
    assign s_r_id_o   = ar_id;
    assign s_r_last_o = s_r_valid_o & last_beat;
    assign m_ar_id_o  = ar_id;

    // Narrow last is count-based; wide last/ID and the high length bits carry no information here.
    logic unused_ok;
    assign unused_ok = ^{m_r_last_i, m_r_id_i, in_block_diff[AXI_ADDR_WIDTH-1:8]};

endmodule

// File: tb/tb_read_upsize.sv
// tb_read_upsize: directed table plus randomized bursts for read_upsize, scored against an AXI
// address-sequence model of each narrow burst.
`timescale 1ns/1ps
module tb_read_upsize;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         s_ar_valid_i = 1'b0, s_ar_ready_o;
    logic [31:0]  s_ar_addr_i = '0;
    logic [7:0]   s_ar_len_i = '0;
    logic [2:0]   s_ar_size_i = '0, s_ar_prot_i = '0;
    logic [1:0]   s_ar_burst_i = '0;
    logic [3:0]   s_ar_region_i = '0, s_ar_cache_i = '0, s_ar_qos_i = '0;
    logic         s_ar_lock_i = 1'b0;
    logic [4:0]   s_ar_id_i = '0;
    logic [5:0]   s_ar_user_i = '0;
    logic         s_r_valid_o, s_r_ready_i = 1'b0, s_r_last_o;
    logic [31:0]  s_r_data_o;
    logic [1:0]   s_r_resp_o;
    logic [4:0]   s_r_id_o;
    logic [5:0]   s_r_user_o;
    logic         m_ar_valid_o, m_ar_ready_i = 1'b0, m_ar_lock_o;
    logic [31:0]  m_ar_addr_o;
    logic [7:0]   m_ar_len_o;
    logic [2:0]   m_ar_size_o, m_ar_prot_o;
    logic [1:0]   m_ar_burst_o;
    logic [3:0]   m_ar_region_o, m_ar_cache_o, m_ar_qos_o;
    logic [4:0]   m_ar_id_o;
    logic [5:0]   m_ar_user_o;
    logic         m_r_valid_i = 1'b0, m_r_ready_o, m_r_last_i = 1'b0;
    logic [127:0] m_r_data_i = '0;
    logic [1:0]   m_r_resp_i = '0;
    logic [4:0]   m_r_id_i = '0;
    logic [5:0]   m_r_user_i = '0;

    read_upsize dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o), .s_ar_addr_i(s_ar_addr_i),
        .s_ar_len_i(s_ar_len_i), .s_ar_size_i(s_ar_size_i), .s_ar_burst_i(s_ar_burst_i),
        .s_ar_prot_i(s_ar_prot_i), .s_ar_region_i(s_ar_region_i), .s_ar_lock_i(s_ar_lock_i),
        .s_ar_cache_i(s_ar_cache_i), .s_ar_qos_i(s_ar_qos_i), .s_ar_id_i(s_ar_id_i),
        .s_ar_user_i(s_ar_user_i),
        .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i), .s_r_data_o(s_r_data_o),
        .s_r_resp_o(s_r_resp_o), .s_r_last_o(s_r_last_o), .s_r_id_o(s_r_id_o), .s_r_user_o(s_r_user_o),
        .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i), .m_ar_addr_o(m_ar_addr_o),
        .m_ar_len_o(m_ar_len_o), .m_ar_size_o(m_ar_size_o), .m_ar_burst_o(m_ar_burst_o),
        .m_ar_prot_o(m_ar_prot_o), .m_ar_region_o(m_ar_region_o), .m_ar_lock_o(m_ar_lock_o),
        .m_ar_cache_o(m_ar_cache_o), .m_ar_qos_o(m_ar_qos_o), .m_ar_id_o(m_ar_id_o),
        .m_ar_user_o(m_ar_user_o),
        .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o), .m_r_data_i(m_r_data_i),
        .m_r_resp_i(m_r_resp_i), .m_r_last_i(m_r_last_i), .m_r_id_i(m_r_id_i), .m_r_user_i(m_r_user_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] cap_data[$];
    logic [1:0]  cap_resp[$];
    logic [31:0] cap_maddr;
    logic [7:0]  cap_mlen;
    logic [2:0]  cap_msize;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] m_addr;
        logic [7:0]  m_len;
        logic [2:0]  m_size;
        int          nbeats;
        logic [7:0][7:0] kj;   // per narrow beat: {wide beat index, lane}
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one narrow burst end to end. rnd enables random handshakes and data; err_beat marks the
    // wide beat answered with SLVERR; abort_after >= 0 stops once that many narrow beats are taken.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input bit rnd, input int err_beat,
                             input int abort_after, input string tag);
        logic [31:0]  na[$];
        logic [127:0] wd[$];
        logic [1:0]   wr[$];
        logic [5:0]   wu[$];
        logic [31:0]  bytes, aligned, total, lower, a, exp_maddr;
        logic [7:0]   exp_mlen;
        logic [2:0]   eff, exp_msize;
        logic [127:0] w;
        logic [1:0]   ln;
        logic [24:0]  side;
        bit           incr, fired, ar_done, ar_now;
        int           nwide, wk, ni, target, widx;

        cap_data.delete();
        cap_resp.delete();
        eff     = (size > 3'd2) ? 3'd2 : size;
        incr    = (burst != 2'b00) && (burst != 2'b10);
        bytes   = 32'd1 << eff;
        aligned = addr & ~(bytes - 32'd1);
        total   = (32'(len) + 32'd1) * bytes;
        lower   = (addr / total) * total;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == 0 || burst == 2'b00)  na.push_back(addr);
            else if (burst == 2'b10)       na.push_back(lower + ((aligned - lower + 32'(i) * bytes) % total));
            else                           na.push_back(aligned + 32'(i) * bytes);
        end
        if (incr) begin
            nwide     = int'((na[len] >> 4) - (na[0] >> 4)) + 1;
            exp_maddr = addr & ~32'hF;
            exp_mlen  = 8'(nwide - 1);
            exp_msize = 3'd4;
        end else begin
            nwide     = int'(len) + 1;
            exp_maddr = addr;
            exp_mlen  = len;
            exp_msize = eff;
        end
        for (int k = 0; k < nwide; k++) begin
            if (rnd) w = {$urandom, $urandom, $urandom, $urandom};
            else for (int j = 0; j < 4; j++) w[32*j +: 32] = 32'hD000_0000 | (32'(k) << 8) | 32'(j);
            wd.push_back(w);
            wr.push_back(k == err_beat ? 2'b10 : 2'b00);
            wu.push_back(rnd ? 6'($urandom) : 6'(k));
        end

        side = rnd ? 25'($urandom) : 25'h0ABCDEF;
        {s_ar_prot_i, s_ar_region_i, s_ar_lock_i, s_ar_cache_i, s_ar_qos_i, s_ar_id_i} = side[24:6];
        s_ar_user_i  = side[5:0];
        s_ar_addr_i  = addr;
        s_ar_len_i   = len;
        s_ar_size_i  = size;
        s_ar_burst_i = burst;
        s_ar_valid_i = 1'b1;
        fired = 0;
        for (int c = 0; c < 50 && !fired; c++) begin
            fired = s_ar_ready_o;
            step();
        end
        s_ar_valid_i = 1'b0;
        check({tag, "_ar_accept"}, 64'(fired), 64'd1);

        target  = (abort_after >= 0) ? abort_after : int'(len) + 1;
        ar_done = 0;
        wk = 0;
        ni = 0;
        for (int cyc = 0; cyc < 4000 && ni < target; cyc++) begin
            ar_now = 0;
            m_ar_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (m_ar_valid_o && m_ar_ready_i) begin
                ar_now    = 1;
                cap_maddr = m_ar_addr_o;
                cap_mlen  = m_ar_len_o;
                cap_msize = m_ar_size_o;
                check({tag, "_m_ar"}, {m_ar_addr_o, m_ar_len_o, m_ar_size_o, m_ar_burst_o},
                      {exp_maddr, exp_mlen, exp_msize, burst});
                check({tag, "_m_ar_side"},
                      {m_ar_prot_o, m_ar_region_o, m_ar_lock_o, m_ar_cache_o, m_ar_qos_o, m_ar_id_o, m_ar_user_o},
                      64'(side));
            end
            m_r_valid_i = ar_done && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            m_r_data_i  = (wk < nwide) ? wd[wk] : '1;
            m_r_resp_i  = (wk < nwide) ? wr[wk] : 2'b11;
            m_r_user_i  = (wk < nwide) ? wu[wk] : '1;
            m_r_last_i  = 1'($urandom);
            m_r_id_i    = 5'($urandom);
            if (m_r_valid_i && m_r_ready_o) wk++;

            s_r_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (s_r_valid_o && s_r_ready_i) begin
                a    = na[ni];
                ln   = a[3:2];
                widx = incr ? int'((a >> 4) - (na[0] >> 4)) : ni;
                w    = (widx < nwide) ? wd[widx] : '0;
                check($sformatf("%s_beat%0d", tag, ni),
                      {s_r_last_o, s_r_resp_o, s_r_id_o, s_r_user_o, s_r_data_o},
                      {ni == int'(len), (widx < nwide) ? wr[widx] : 2'b00, side[10:6],
                       (widx < nwide) ? wu[widx] : 6'd0, w[32*ln +: 32]});
                cap_data.push_back(s_r_data_o);
                cap_resp.push_back(s_r_resp_o);
                ni++;
            end
            if (ar_now) ar_done = 1;
            step();
        end
        check({tag, "_narrow_count"}, 64'(ni), 64'(target));
        if (abort_after < 0) begin
            m_r_valid_i  = 1'b0;
            s_r_ready_i  = 1'b0;
            m_ar_ready_i = 1'b0;
            check({tag, "_wide_count"}, 64'(wk), 64'(nwide));
            check({tag, "_back_idle"}, {s_ar_ready_o, s_r_valid_o}, 2'b10);
        end
    endtask

    vec_t vecs[4];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"s1_incr", 32'h1000, 8'd7, 3'd2, 2'b01, 32'h1000, 8'd1, 3'd4, 8,
                    {8'h13, 8'h12, 8'h11, 8'h10, 8'h03, 8'h02, 8'h01, 8'h00}};
        vecs[1] = '{"s2_cross", 32'h100C, 8'd1, 3'd2, 2'b01, 32'h1000, 8'd1, 3'd4, 2,
                    {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h03}};
        vecs[2] = '{"s3_byte", 32'h0003, 8'd3, 3'd0, 2'b01, 32'h0000, 8'd0, 3'd4, 4,
                    {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00}};
        vecs[3] = '{"s4_fixed", 32'h2004, 8'd3, 3'd2, 2'b00, 32'h2004, 8'd3, 3'd2, 4,
                    {8'h00, 8'h00, 8'h00, 8'h00, 8'h31, 8'h21, 8'h11, 8'h01}};

        // Reset state, checked while reset is held and after release.
        repeat (3) step();
        check("rst_outputs", {s_ar_ready_o, m_ar_valid_o, s_r_valid_o, m_r_ready_o, s_r_last_o},
              5'b00000);
        check("rst_data", {s_r_data_o, s_r_id_o, m_ar_addr_o}, 64'd0);
        rst_i = 1'b0;
        step();
        check("rst_release_ready", {s_ar_ready_o, m_ar_valid_o}, 2'b10);

        // Directed table: wide AR against fixed values, narrow beats against {wide beat, lane}.
        for (int v = 0; v < 4; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 1'b0, -1, -1, vecs[v].name);
            check({vecs[v].name, "_tbl_m_ar"}, {cap_maddr, cap_mlen, cap_msize},
                  {vecs[v].m_addr, vecs[v].m_len, vecs[v].m_size});
            for (int i = 0; i < vecs[v].nbeats && i < cap_data.size(); i++)
                check($sformatf("%s_tbl_lane%0d", vecs[v].name, i),
                      {cap_data[i][11:8], cap_data[i][3:0]}, vecs[v].kj[i]);
        end

        // Random handshakes with SLVERR on the second wide beat.
        run_burst(32'h1000, 8'd7, 3'd2, 2'b01, 1'b1, 1, -1, "s5_err");
        for (int i = 0; i < 8 && i < cap_resp.size(); i++)
            check($sformatf("s5_resp%0d", i), 64'(cap_resp[i]), (i >= 4) ? 64'd2 : 64'd0);

        // Reset after the third narrow beat, then a fresh burst.
        run_burst(32'h1000, 8'd7, 3'd2, 2'b01, 1'b0, -1, 3, "s6_pre");
        rst_i = 1'b1;
        step();
        check("s6_rst_valids", {s_ar_ready_o, m_ar_valid_o, s_r_valid_o, m_r_ready_o}, 4'b0000);
        step();
        check("s6_rst_hold", {s_r_valid_o, m_r_ready_o, s_r_data_o}, 34'd0);
        rst_i = 1'b0;
        m_r_valid_i = 1'b0;
        s_r_ready_i = 1'b0;
        m_ar_ready_i = 1'b0;
        step();
        check("s6_post_ready", {s_ar_ready_o, s_r_valid_o, m_ar_valid_o}, 3'b100);
        run_burst(32'h1000, 8'd7, 3'd2, 2'b01, 1'b1, -1, -1, "s6_post");

        // Randomized bursts of all legal types.
        for (int r = 0; r < 24; r++) begin
            logic [1:0]  b;
            logic [2:0]  sz;
            logic [7:0]  ln;
            logic [31:0] ad;
            int          pick;
            pick = int'($urandom_range(0, 3));
            b    = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b10 : 2'b01;
            sz   = 3'($urandom_range(0, 2));
            ad   = $urandom & 32'h0FFF_FFFF;
            if (b == 2'b10) begin
                ln = 8'((1 << $urandom_range(1, 4)) - 1);
                ad = ad & ~((32'd1 << sz) - 32'd1);
            end else begin
                ln = 8'($urandom_range(0, 15));
            end
            if (b == 2'b01 && $urandom_range(0, 4) == 0) sz = 3'($urandom_range(3, 7));
            if (r == 7) begin
                b  = 2'b01;
                ln = 8'd255;
            end
            run_burst(ad, ln, sz, b, 1'b1, int'($urandom_range(0, 4)) - 1, -1, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/read_upsize.md
Name: read_upsize

Overview:
- AXI4 read-channel width converter: 32-bit AXI slave port (AR/R) to 128-bit AXI master port.
- Read-side counterpart of the write upsizer, sitting between narrow 32-bit initiators and the 128-bit interconnect.
- Converts a narrow AR into an equivalent wide AR, then splits each returned 128-bit R beat into the 32-bit beats the narrow master expects.
- One outstanding burst at a time.

Parameters:
- AXI_ADDR_WIDTH, 32, address width on both ports
- AXI_DATA_WIDTH_IN, 32, slave-side data width
- AXI_DATA_WIDTH_OUT, 128, master-side data width; must be 4x AXI_DATA_WIDTH_IN
- AXI_ID_WIDTH, 5, ID width on both ports
- AXI_USER_WIDTH, 6, user width on both ports

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- s_ar_valid_i / s_ar_ready_o  in/out  1  slave AR handshake
- s_ar_addr_i  in  ADDR  slave AR address
- s_ar_len_i  in  8  slave AR burst length
- s_ar_size_i  in  3  slave AR size; 0..2 legal
- s_ar_burst_i  in  2  slave AR burst type
- s_ar_prot_i  in  3  slave AR protection
- s_ar_region_i  in  4  slave AR region
- s_ar_lock_i  in  1  slave AR lock
- s_ar_cache_i  in  4  slave AR cache
- s_ar_qos_i  in  4  slave AR QoS
- s_ar_id_i  in  ID  slave AR ID
- s_ar_user_i  in  USER  slave AR user
- s_r_valid_o / s_r_ready_i  out/in  1  narrow R handshake
- s_r_data_o  out  32  narrow read data
- s_r_resp_o  out  2  narrow read response
- s_r_last_o  out  1  narrow last beat
- s_r_id_o  out  ID  narrow R ID
- s_r_user_o  out  USER  narrow R user
- m_ar_* (valid_o, ready_i, addr, len, size, burst, prot, region, lock, cache, qos, id, user)  mirror of the s_ar_* set  wide AR channel
- m_r_valid_i / m_r_ready_o  in/out  1  wide R handshake
- m_r_data_i  in  128  wide read data
- m_r_resp_i  in  2  wide read response
- m_r_last_i  in  1  wide last beat
- m_r_id_i  in  ID  wide R ID
- m_r_user_i  in  USER  wide R user

Behaviour:
Reset:
- On rst_i=1 at a clock edge: state=IDLE, buffer empty.
- Outputs during reset: s_ar_ready_o=0, m_ar_valid_o=0, s_r_valid_o=0, m_r_ready_o=0, all data/ID outputs 0.
- Reset mid-burst abandons the burst with no further beats on either side.

FSM IDLE -> AR_SEND -> DATA -> IDLE.

IDLE:
- s_ar_ready_o=1.
- On s_ar_valid_i: register all AR fields; go to AR_SEND next cycle.

AR_SEND:
- m_ar_valid_o=1, held stable until m_ar_ready_i; then go to DATA.
- prot/region/lock/cache/qos/id/user pass through unchanged.
- INCR: m_ar_addr = addr with bits[3:0] cleared; m_ar_size=4; m_ar_len = (last_byte>>4) - (addr>>4), where last_byte = (addr & ~(2^size-1)) + len*2^size. Maximum m_ar_len is 64, so no overflow.
- FIXED and WRAP: addr/len/size/burst forwarded unchanged, giving a 1:1 beat mapping.

DATA:
- One-entry wide buffer (data, resp, user).
- m_r_ready_o = ~buf_valid; a wide beat is accepted when m_r_valid_i & m_r_ready_o.
- s_r_valid_o = buf_valid, so the first narrow beat appears 1 cycle after wide acceptance.
- s_r_data_o = buf_data[32*cur_addr[3:2] +: 32].
- s_r_resp_o = buffered resp; s_r_id_o = registered AR ID; s_r_user_o = buffered user.

Narrow beat accepted (s_r_valid_o & s_r_ready_i):
- Beat counter increments.
- cur_addr advances per AXI rules:
  - INCR: aligned(addr) + 2^size.
  - WRAP: same advance, wrapped inside boundary (len+1)*2^size.
  - FIXED: unchanged.
- Buffer is released (buf_valid cleared) when the next cur_addr crosses a 16-byte boundary, the burst is FIXED or WRAP, or the beat is last.
- Release and a new wide accept cannot occur in the same cycle, because ready depends on ~buf_valid.

Last beat:
- s_r_last_o=1 when beat counter == registered len.
- On the last narrow accept: return to IDLE; a new AR can be accepted the following cycle.

Robustness:
- m_r_last_i and m_r_id_i are ignored; narrow last is count-based.
- An early wide last does not terminate the narrow burst.
- s_ar_size > 2 is not supported: treated as size 2.

Test Plan:
1. INCR, addr 0x1000, len 7, size 2, wide ready always 1 -> m_ar addr 0x1000 len 1 size 4; 8 narrow beats = lanes 0,1,2,3 of wide beat 0, then of beat 1; last on the 8th.
2. INCR, addr 0x100C, len 1, size 2 -> m_ar addr 0x1000 len 1; narrow beat 0 = wide0[127:96], beat 1 = wide1[31:0].
3. INCR, addr 0x0003, len 3, size 0 -> m_ar len 0; all 4 narrow beats from one wide beat, lanes 0,1,1,1; m_r_ready_o stays 0 after the first accept.
4. FIXED, addr 0x2004, len 3, size 2 -> m_ar forwarded unchanged; each of 4 wide beats yields one narrow beat from lane 1.
5. Random s_r_ready_i and m_r_valid_i with the scenario 1 burst, wide resp SLVERR on beat 1 -> data order intact; narrow beats 4-7 carry resp 2'b10; no lost or duplicated beats.
6. rst_i asserted after the 3rd narrow beat of scenario 1 -> next cycle all valids 0, s_ar_ready_o=0; after reset release, s_ar_ready_o=1 and a new burst completes correctly.
